axis_vc_arbiter: RTL and testbench

//  Transmit-side counterpart of the per-channel AXI-Stream FIFO bank. Drains CHANNEL_NUMBER buffered

---
 rtl/axis_vc_arbiter_pkg.sv | 45 ++++
 rtl/axis_skid_slice.sv | 61 ++++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/axis_vc_arbiter.sv | 151 +++++++++++++++
 tb/tb_axis_vc_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_vc_arbiter_pkg.sv
// Shared AXI-Stream and arbiter types for axis_vc_arbiter.
// Sideband fields appear only under TID_PRESENT / TDEST_PRESENT / TUSER_PRESENT.
package axis_vc_arbiter_pkg;

  localparam int AXIS_VC_CH_DEFAULT = 8;
  localparam int DATA_WIDTH         = 32;
`ifdef TID_PRESENT
  localparam int ID_WIDTH           = 4;
`endif
`ifdef TDEST_PRESENT
  localparam int DEST_WIDTH         = 4;
`endif
`ifdef TUSER_PRESENT
  localparam int USER_WIDTH         = 4;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
`ifdef TID_PRESENT
    logic [ID_WIDTH-1:0]   tid;
`endif
`ifdef TDEST_PRESENT
    logic [DEST_WIDTH-1:0] tdest;
`endif
`ifdef TUSER_PRESENT
    logic [USER_WIDTH-1:0] tuser;
`endif
    logic                  tlast;
  } axis_data_t;

  typedef struct packed {
    axis_data_t data;
    logic       tvalid;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry skid buffer: registered output, full throughput, and in_ready_o
// depends only on occupancy so there is no combinational path from out_ready_i.
module axis_skid_slice #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  always_comb begin
    in_ready_o  = (cnt_q != 2'd2);
    out_valid_o = (cnt_q != 2'd0);
    out_data_o  = mem_q[rd_q];
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;
    mem_d       = mem_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    if (push) begin
      mem_d[wr_q] = in_data_i;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted request scanning from ptr_i upward,
// wrapping modulo N. Purely combinational so it can be reused by other routers.
module rr_arbiter #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int cand;
    cand  = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_vc_arbiter.sv
// Packet-atomic round-robin merge of CHANNEL_NUMBER AXI-Stream inputs onto one link.
// Define AXIS_VC_ARB_OUT_REG_EN to register the output through a 2-entry skid slice.
//
// Handshake rule: a beat moves when the selected channel's tvalid and the
// downstream ready (link TREADY, or skid-not-full when registered) are both high;
// that is the only event that changes grant, lock state or the rr pointer.
module axis_vc_arbiter
  import axis_vc_arbiter_pkg::*;
#(
  parameter int CHANNEL_NUMBER = AXIS_VC_CH_DEFAULT
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  axis_mosi_t [CHANNEL_NUMBER-1:0]   in_mosi_i,
  output axis_miso_t [CHANNEL_NUMBER-1:0]   in_miso_o,
  output axis_mosi_t                        out_mosi_o,
  input  axis_miso_t                        out_miso_i,
  output logic [$clog2(CHANNEL_NUMBER)-1:0] grant_o,
  output logic                              locked_o
);

  localparam int CH_IDX_W = $clog2(CHANNEL_NUMBER);

  arb_state_e                state_q, state_d;
  logic [CH_IDX_W-1:0]       ptr_q, ptr_d;
  logic [CH_IDX_W-1:0]       grant_q, grant_d;
  logic                      hold_q, hold_d;
  logic [CH_IDX_W-1:0]       hold_idx_q, hold_idx_d;

  logic [CHANNEL_NUMBER-1:0] req;
  logic [CHANNEL_NUMBER-1:0] rr_gnt;
  logic [CH_IDX_W-1:0]       rr_idx;
  logic                      rr_any;

  logic [CH_IDX_W-1:0]       sel;
  logic [CHANNEL_NUMBER-1:0] sel_oh;
  logic                      active;
  axis_data_t                mux_data;
  logic                      mux_valid;
  logic                      down_ready;
  logic                      hs;

  always_comb begin
    for (int c = 0; c < CHANNEL_NUMBER; c++) req[c] = in_mosi_i[c].tvalid;
  end

  rr_arbiter #(.N(CHANNEL_NUMBER)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  // Next state. A stalled IDLE pick is held so a newly valid, higher-priority
  // channel cannot swap the beat presented while downstream is not ready.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    hold_d     = (state_q == ARB_IDLE) && mux_valid && !hs;
    hold_idx_d = sel;
    if (hs) begin
      grant_d = sel;
      if (mux_data.tlast) begin
        state_d = ARB_IDLE;
        ptr_d   = (sel == CH_IDX_W'(CHANNEL_NUMBER - 1)) ? '0 : sel + CH_IDX_W'(1);
      end else begin
        state_d = ARB_LOCKED;
      end
    end
  end

  // Outputs: channel select, data mux and per-input ready
  always_comb begin
    sel    = rr_idx;
    sel_oh = rr_gnt;
    active = rr_any;
    if (state_q == ARB_LOCKED) begin
      sel    = grant_q;
      active = 1'b1;
    end else if (hold_q) begin
      sel    = hold_idx_q;
      active = 1'b1;
    end
    if (state_q == ARB_LOCKED || hold_q) begin
      sel_oh      = '0;
      sel_oh[sel] = 1'b1;
    end
    if (ARESET) begin
      active = 1'b0;
      sel_oh = '0;
    end
    mux_data  = active ? in_mosi_i[sel].data : '0;
    mux_valid = active & in_mosi_i[sel].tvalid;
    hs        = mux_valid & down_ready;
    in_miso_o = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) in_miso_o[c].tready = sel_oh[c] & down_ready;
    grant_o   = grant_q;
    locked_o  = (state_q == ARB_LOCKED);
  end

`ifdef AXIS_VC_ARB_OUT_REG_EN
  logic       skid_in_ready;
  logic       skid_out_valid;
  axis_data_t skid_out_data;

  axis_skid_slice #(.W($bits(axis_data_t))) u_skid (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .in_valid_i  (mux_valid),
    .in_data_i   (mux_data),
    .in_ready_o  (skid_in_ready),
    .out_valid_o (skid_out_valid),
    .out_data_o  (skid_out_data),
    .out_ready_i (out_miso_i.tready)
  );

  assign down_ready = skid_in_ready;

  always_comb begin
    out_mosi_o.data   = skid_out_data;
    out_mosi_o.tvalid = skid_out_valid & ~ARESET;
  end
`else
  assign down_ready = out_miso_i.tready;

  always_comb begin
    out_mosi_o.data   = mux_data;
    out_mosi_o.tvalid = mux_valid;
  end
`endif

endmodule

// File: tb/tb_axis_vc_arbiter.sv
// Directed + randomized bench for axis_vc_arbiter; builds with or without
// AXIS_VC_ARB_OUT_REG_EN (adds one cycle of output latency).
module tb_axis_vc_arbiter;
  import axis_vc_arbiter_pkg::*;

  localparam int CH = 8;
  localparam int BW = DATA_WIDTH + 1;
`ifdef AXIS_VC_ARB_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  // clock / reset
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axis_mosi_t [CH-1:0] in_mosi;
  axis_miso_t [CH-1:0] in_miso;
  axis_mosi_t          out_mosi;
  axis_miso_t          out_miso;
  logic [2:0]          grant;
  logic                locked;

  axis_vc_arbiter #(.CHANNEL_NUMBER(CH)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .in_mosi_i  (in_mosi),
    .in_miso_o  (in_miso),
    .out_mosi_o (out_mosi),
    .out_miso_i (out_miso),
    .grant_o    (grant),
    .locked_o   (locked)
  );

  int total = 0;
  int bad   = 0;

  // sources and scoreboard
  logic [BW-1:0] src_q [CH][$];
  logic [BW-1:0] exp_q [CH][$];
  logic          drv_valid [CH];
  logic [BW-1:0] drv_beat  [CH];
  int            hold_off  [CH];
  int            sent      [CH];
  int            bub_at    [CH];
  int            bub_len   [CH];
  int            vprob     [CH];
  int            wait_pk   [CH];
  logic          acc       [CH];
  int            rprob;
  logic          out_ready;
  int            cyc;
  int            seq;

  // reference model of registered status and output ordering
  logic       m_locked;
  int         m_grant;
  logic       o_in_pkt;
  int         o_cur_ch;
  logic       prev_stall;
  axis_data_t prev_data;
  int         log_ch[$];
  int         log_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic add_pkt(input int c, input int len);
    logic [BW-1:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), 4'(c), 12'($urandom), 16'(seq)};
      seq++;
      src_q[c].push_back(b);
      exp_q[c].push_back(b);
    end
  endtask

  task automatic drive_dut();
    for (int c = 0; c < CH; c++) begin
      in_mosi[c]            = '0;
      in_mosi[c].tvalid     = drv_valid[c];
      in_mosi[c].data.tdata = drv_beat[c][DATA_WIDTH-1:0];
      in_mosi[c].data.tlast = drv_beat[c][DATA_WIDTH];
    end
    out_miso.tready = out_ready;
  endtask

  // driver: valid stays up until accepted; new beats appear at random
  task automatic update();
    for (int c = 0; c < CH; c++) begin
      if (acc[c]) begin
        void'(src_q[c].pop_front());
        drv_valid[c] = 1'b0;
        sent[c]++;
        if (sent[c] == bub_at[c]) hold_off[c] = bub_len[c];
      end
      acc[c] = 1'b0;
      if (!drv_valid[c]) begin
        if (hold_off[c] > 0) hold_off[c]--;
        else if (src_q[c].size() > 0 && $urandom_range(99) < vprob[c]) begin
          drv_valid[c] = 1'b1;
          drv_beat[c]  = src_q[c][0];
        end
      end
    end
    out_ready = ($urandom_range(99) < rprob);
    drive_dut();
  endtask

  task automatic sample();
    logic [CH-1:0] rdy;
    logic [BW-1:0] beat;
    logic          out_hs;
    int            ch;
    for (int c = 0; c < CH; c++) rdy[c] = in_miso[c].tready;
    out_hs = out_mosi.tvalid & out_miso.tready;
    if (ARESET) begin
      check("rst_out_valid", out_mosi.tvalid, 0);
      check("rst_tready", rdy, 0);
      for (int c = 0; c < CH; c++) acc[c] = 1'b0;
      m_locked = 1'b0; m_grant = 0; o_in_pkt = 1'b0; prev_stall = 1'b0;
      return;
    end
    check("tready_onehot", $countones(rdy) <= 1, 1);
    check("locked", locked, m_locked);
    check("grant", grant, m_grant);
    if (m_locked) check("tready_owner_only", rdy & ~(CH'(1) << m_grant), 0);
    if (prev_stall) check("stall_hold", {out_mosi.tvalid, out_mosi.data}, {1'b1, prev_data});
    if (out_hs) begin
      beat = {out_mosi.data.tlast, out_mosi.data.tdata};
      ch   = int'(beat[DATA_WIDTH-1 -: 4]);
      check("out_ch_range", ch < CH, 1);
      if (ch < CH) begin
        check("exp_nonempty", exp_q[ch].size() > 0, 1);
        if (exp_q[ch].size() > 0) check("beat", beat, exp_q[ch].pop_front());
        if (o_in_pkt) check("no_interleave", ch, o_cur_ch);
        o_in_pkt = !beat[DATA_WIDTH];
        o_cur_ch = ch;
        log_ch.push_back(ch);
        log_cyc.push_back(cyc);
      end
    end
    prev_stall = out_mosi.tvalid & !out_miso.tready;
    prev_data  = out_mosi.data;
    for (int c = 0; c < CH; c++) begin
      acc[c] = drv_valid[c] & rdy[c];
      if (acc[c]) begin
        wait_pk[c] = 0;
        if (drv_beat[c][DATA_WIDTH]) begin
          for (int d = 0; d < CH; d++) begin
            if (d != c && drv_valid[d]) begin
              wait_pk[d]++;
              check("fairness", wait_pk[d] <= CH - 1, 1);
            end
          end
        end
        m_grant  = c;
        m_locked = !drv_beat[c][DATA_WIDTH];
      end
    end
  endtask

  task automatic cycle();
    @(negedge ACLK);
    sample();
    @(posedge ACLK);
    #1;
    cyc++;
    update();
  endtask

  function automatic bit pending();
    for (int c = 0; c < CH; c++) if (exp_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check(tag, pending(), 0);
  endtask

  task automatic clear_log();
    log_ch.delete();
    log_cyc.delete();
  endtask

  initial begin
    int rel_cyc, s0, n, nbeats;
    int t4_ord[5];
    int t4_gap[4];
    t4_ord = '{3, 3, 3, 3, 1};
    t4_gap = '{1, 4, 1, 1};
    cyc = 0; seq = 0; rprob = 100; out_ready = 1'b1;
    m_locked = 1'b0; m_grant = 0; o_in_pkt = 1'b0; o_cur_ch = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < CH; c++) begin
      drv_valid[c] = 1'b0; drv_beat[c] = '0; hold_off[c] = 0; sent[c] = 0;
      bub_at[c] = -1; bub_len[c] = 0; vprob[c] = 100; wait_pk[c] = 0; acc[c] = 1'b0;
    end

    // reset with every channel valid, then all-single-beat round robin
    for (int r = 0; r < 2; r++) for (int c = 0; c < CH; c++) add_pkt(c, 1);
    update();
    cycle();
    check("rst_locked", locked, 0);
    check("rst_grant", grant, 0);
    cycle();
    cycle();
    ARESET = 1'b0;
    rel_cyc = cyc;
    clear_log();
    run_drain(100, "t2_drain");
    check("t2_count", log_ch.size(), 2 * CH);
    if (log_ch.size() == 2 * CH) begin
      check("t1_first_latency", log_cyc[0], rel_cyc + LAT);
      for (int i = 0; i < 2 * CH; i++) begin
        check("t2_order", log_ch[i], i % CH);
        check("t2_rate", log_cyc[i], log_cyc[0] + i);
      end
    end

    // 4-beat packet on ch2, ch5 arrives during beat 2
    clear_log();
    hold_off[5] = 1;
    add_pkt(2, 4);
    add_pkt(5, 1);
    update();
    run_drain(50, "t3_drain");
    check("t3_count", log_ch.size(), 5);
    if (log_ch.size() == 5) begin
      for (int i = 0; i < 4; i++) check("t3_ch2", log_ch[i], 2);
      check("t3_ch5", log_ch[4], 5);
      check("t3_span", log_cyc[4] - log_cyc[0], 4);
    end

    // ch3 bubbles for 3 clocks mid-packet while ch1 waits
    clear_log();
    hold_off[1] = 1;
    bub_at[3] = sent[3] + 2;
    bub_len[3] = 3;
    add_pkt(3, 4);
    add_pkt(1, 1);
    update();
    run_drain(50, "t4_drain");
    bub_at[3] = -1;
    check("t4_count", log_ch.size(), 5);
    if (log_ch.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t4_order", log_ch[i], t4_ord[i]);
      for (int i = 0; i < 4; i++) check("t4_gap", log_cyc[i+1] - log_cyc[i], t4_gap[i]);
    end

    // random backpressure, three channels of random-length packets
    clear_log();
    rprob = 50;
    nbeats = 0;
    vprob[0] = 70; vprob[4] = 70; vprob[6] = 70;
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 6); add_pkt(0, n); nbeats += n;
      n = $urandom_range(1, 6); add_pkt(4, n); nbeats += n;
      n = $urandom_range(1, 6); add_pkt(6, n); nbeats += n;
    end
    update();
    run_drain(3000, "t5_drain");
    check("t5_beats", log_ch.size(), nbeats);
    rprob = 100;
    vprob[0] = 100; vprob[4] = 100; vprob[6] = 100;

    // reset in the middle of a ch4 packet
    add_pkt(4, 6);
    update();
    s0 = sent[4];
    n = 0;
    while (sent[4] < s0 + 2 && n < 20) begin
      cycle();
      n++;
    end
    check("t6_started", sent[4] - s0, 2);
    check("t6_locked_before", locked, 1);
    ARESET = 1'b1;
    cycle();
    check("t6_locked", locked, 0);
    check("t6_grant", grant, 0);
    for (int c = 0; c < CH; c++) begin
      src_q[c].delete(); exp_q[c].delete();
      drv_valid[c] = 1'b0; wait_pk[c] = 0; hold_off[c] = 0;
    end
    ARESET = 1'b0;
    clear_log();
    add_pkt(7, 1);
    add_pkt(1, 1);
    update();
    run_drain(20, "t6_drain");
    check("t6_count", log_ch.size(), 2);
    if (log_ch.size() == 2) begin
      check("t6_ptr0_first", log_ch[0], 1);
      check("t6_second", log_ch[1], 7);
    end

    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
